// File: rtl/rle_decompressor_if.sv
// Bus between the compressed-stream source / RAM-input mux and the run-length decoder.
// The decoder takes the slave modport; whatever drives Start and the stream takes master.
interface rle_decompressor_if #(
    parameter int ADDR_W = 16
);
    logic              Start;
    logic [ADDR_W-1:0] NumPixels;
    logic [7:0]        InData;
    logic              InValid;
    logic              InReady;
    logic [7:0]        DataInDecompressed;
    logic              WriteEnable;
    logic [ADDR_W-1:0] Address;
    logic              Busy;
    logic              Done;
    logic              Overrun;

    modport slave (
        input  Start, NumPixels, InData, InValid,
        output InReady, DataInDecompressed, WriteEnable, Address, Busy, Done, Overrun
    );

    modport master (
        output Start, NumPixels, InData, InValid,
        input  InReady, DataInDecompressed, WriteEnable, Address, Busy, Done, Overrun
    );
endinterface

// File: rtl/rle_decompressor.sv
// Expands (count, value) byte pairs into one RAM write per cycle until NumPixels bytes
// have been written, then pulses Done. Every output is decoded from registered state.
module rle_decompressor #(
    parameter int ADDR_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    rle_decompressor_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE,
        GET_COUNT,
        GET_VALUE,
        EMIT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] numPix_q, numPix_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        run_q, run_d;
    logic [7:0]        value_q, value_d;
    logic              overrun_q, overrun_d;

    logic inReady;
    logic xfer;
    logic lastWrite;

    assign inReady   = (state_q == GET_COUNT) || (state_q == GET_VALUE);
    assign xfer      = inReady && bus.InValid;
    assign lastWrite = (addr_q == (numPix_q - ADDR_W'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            numPix_q  <= '0;
            addr_q    <= '0;
            run_q     <= '0;
            value_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            numPix_q  <= numPix_d;
            addr_q    <= addr_d;
            run_q     <= run_d;
            value_q   <= value_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        numPix_d  = numPix_q;
        addr_d    = addr_q;
        run_d     = run_q;
        value_d   = value_q;
        overrun_d = overrun_q;

        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    numPix_d  = bus.NumPixels;
                    addr_d    = '0;
                    overrun_d = 1'b0;
                    state_d   = (bus.NumPixels == '0) ? DONE : GET_COUNT;
                end
            end
            GET_COUNT: begin
                // A zero count encodes a full 256-byte run, hence the 9-bit run register.
                if (xfer) begin
                    run_d   = {(bus.InData == 8'd0), bus.InData};
                    state_d = GET_VALUE;
                end
            end
            GET_VALUE: begin
                if (xfer) begin
                    value_d = bus.InData;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                run_d = run_q - 9'd1;
                // The address is held on the final write so it never passes NumPixels-1.
                if (lastWrite) begin
                    state_d = DONE;
                    if (run_q != 9'd1) begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (run_q == 9'd1) begin
                        state_d = GET_COUNT;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.InReady            = inReady;
    assign bus.DataInDecompressed = value_q;
    assign bus.WriteEnable        = (state_q == EMIT);
    assign bus.Address            = addr_q;
    assign bus.Busy               = (state_q != IDLE);
    assign bus.Done               = (state_q == DONE);
    assign bus.Overrun            = overrun_q;

endmodule

// File: tb/tb_rle_decompressor.sv
// Directed bench for rle_decompressor: a table of decodes with hand-computed outcomes,
// plus hand-written sequences for reset during EMIT and a Start pulsed mid-decode.
module tb_rle_decompressor;

    typedef struct packed {
        logic [15:0] numPix;
        logic [3:0]  streamLen;
        logic [63:0] stream;
        logic        toggleValid;
        logic [7:0]  glitchAt;
        logic        chkGaps;
        logic [15:0] expWrites;
        logic        expOverrun;
        logic [3:0]  expXfers;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    always #5 clk = ~clk;

    rle_decompressor_if #(.ADDR_W(16)) bus ();

    rle_decompressor #(.ADDR_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) cycle++;

    logic [15:0] wrAddr[$];
    logic [7:0]  wrData[$];
    int          wrCycle[$];
    int          doneCount = 0;
    int          doneCycle = -1;
    int          xferCount = 0;
    logic        overrunAtDone = 1'b0;
    logic        busyAtDone = 1'b0;
    logic        busyAfterDone = 1'b1;
    logic        prevDone = 1'b0;

    // Observes the bus mid-cycle, well away from the rising edge.
    always @(negedge clk) begin
        if (bus.WriteEnable) begin
            wrAddr.push_back(bus.Address);
            wrData.push_back(bus.DataInDecompressed);
            wrCycle.push_back(cycle);
        end
        if (bus.InReady && bus.InValid) xferCount++;
        if (prevDone) busyAfterDone = bus.Busy;
        if (bus.Done) begin
            doneCount++;
            doneCycle     = cycle;
            overrunAtDone = bus.Overrun;
            busyAtDone    = bus.Busy;
        end
        prevDone = bus.Done;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".InReady"}, 32'(bus.InReady), 32'd0);
        checkOutput({tag, ".WriteEnable"}, 32'(bus.WriteEnable), 32'd0);
        checkOutput({tag, ".Data"}, 32'(bus.DataInDecompressed), 32'd0);
        checkOutput({tag, ".Address"}, 32'(bus.Address), 32'd0);
        checkOutput({tag, ".Busy"}, 32'(bus.Busy), 32'd0);
        checkOutput({tag, ".Done"}, 32'(bus.Done), 32'd0);
        checkOutput({tag, ".Overrun"}, 32'(bus.Overrun), 32'd0);
    endtask

    // Runs one decode; abortAt != 0 returns early once that many writes were seen.
    task automatic applyStimulus(input vec_t v, input int abortAt);
        int   idx = 0;
        int   startCycle;
        int   startDone;
        int   budget;
        int   k;
        int   cnt;
        logic xfer;
        logic glitched = 1'b0;
        logic bad = 1'b0;
        logic [7:0] val;

        wrAddr.delete();
        wrData.delete();
        wrCycle.delete();
        xferCount = 0;
        startDone = doneCount;

        bus.NumPixels = v.numPix;
        bus.Start     = 1'b1;
        startCycle    = cycle;
        tick();
        bus.Start = 1'b0;
        checkOutput("readyAfterStart", 32'(bus.InReady), 32'(v.numPix != 16'd0));
        checkOutput("overrunCleared", 32'(bus.Overrun), 32'd0);

        for (budget = 0; budget < 2000 && doneCount == startDone; budget++) begin
            if (abortAt != 0 && wrAddr.size() >= abortAt) return;
            bus.InData  = (idx < int'(v.streamLen)) ? v.stream[idx*8 +: 8] : 8'h00;
            bus.InValid = (idx < int'(v.streamLen)) && (!v.toggleValid || (budget % 2 == 0));
            if (v.glitchAt != 8'd0 && !glitched && wrAddr.size() == int'(v.glitchAt)) begin
                bus.Start     = 1'b1;
                bus.NumPixels = 16'd2;
                glitched      = 1'b1;
            end else begin
                bus.Start = 1'b0;
            end
            @(negedge clk);
            xfer = bus.InReady && bus.InValid;
            tick();
            if (xfer) idx++;
        end
        bus.InValid = 1'b0;
        bus.Start   = 1'b0;
        tick();
        tick();

        checkOutput("doneCount", 32'(doneCount - startDone), 32'd1);
        checkOutput("overrunAtDone", 32'(overrunAtDone), 32'(v.expOverrun));
        checkOutput("busyAtDone", 32'(busyAtDone), 32'd1);
        checkOutput("busyAfterDone", 32'(busyAfterDone), 32'd0);
        checkOutput("writeCount", 32'(wrAddr.size()), 32'(v.expWrites));
        checkOutput("xferCount", 32'(xferCount), 32'(v.expXfers));
        checkOutput("overrunHold", 32'(bus.Overrun), 32'(v.expOverrun));
        checkOutput("idleReady", 32'(bus.InReady), 32'd0);

        if (v.expWrites != 16'd0 && wrCycle.size() > 0)
            checkOutput("doneAfterLastWrite", 32'(doneCycle), 32'(wrCycle[wrCycle.size()-1] + 1));
        else
            checkOutput("doneLatency", 32'(doneCycle), 32'(startCycle + 1));

        if (v.chkGaps && wrCycle.size() == 6) begin
            checkOutput("firstWriteCycle", 32'(wrCycle[0]), 32'(startCycle + 3));
            checkOutput("run0Length", 32'(wrCycle[2] - wrCycle[0]), 32'd2);
            checkOutput("gapRun0Run1", 32'(wrCycle[3] - wrCycle[2]), 32'd3);
            checkOutput("gapRun1Run2", 32'(wrCycle[4] - wrCycle[3]), 32'd3);
        end

        // Expand the stream pairs independently and compare write by write.
        k = 0;
        for (int p = 0; p < int'(v.streamLen) / 2; p++) begin
            cnt = (v.stream[p*16 +: 8] == 8'd0) ? 256 : int'(v.stream[p*16 +: 8]);
            val = v.stream[p*16 + 8 +: 8];
            for (int j = 0; j < cnt && k < int'(v.numPix); j++) begin
                if (!bad && k < wrAddr.size()) begin
                    checks++;
                    if (wrAddr[k] !== 16'(k) || wrData[k] !== val) begin
                        errors++;
                        bad = 1'b1;
                        $display("[TB] FAIL write%0d: got %0h@%0d expected %0h@%0d", k, wrData[k], wrAddr[k], val, k);
                    end
                end
                k++;
            end
        end
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{numPix:16'd6,   streamLen:4'd6, stream:64'h0000_FF02_0501_AA03, toggleValid:1'b0,
                    glitchAt:8'd0, chkGaps:1'b1, expWrites:16'd6,   expOverrun:1'b0, expXfers:4'd6};
        vecs[1] = '{numPix:16'd300, streamLen:4'd4, stream:64'h0000_0000_012C_7E00, toggleValid:1'b0,
                    glitchAt:8'd0, chkGaps:1'b0, expWrites:16'd300, expOverrun:1'b0, expXfers:4'd4};
        vecs[2] = '{numPix:16'd5,   streamLen:4'd4, stream:64'h0000_0000_4401_3308, toggleValid:1'b0,
                    glitchAt:8'd0, chkGaps:1'b0, expWrites:16'd5,   expOverrun:1'b1, expXfers:4'd2};
        vecs[3] = '{numPix:16'd4,   streamLen:4'd4, stream:64'h0000_0000_2002_1002, toggleValid:1'b1,
                    glitchAt:8'd0, chkGaps:1'b0, expWrites:16'd4,   expOverrun:1'b0, expXfers:4'd4};
        vecs[4] = '{numPix:16'd0,   streamLen:4'd2, stream:64'h0000_0000_0000_9901, toggleValid:1'b0,
                    glitchAt:8'd0, chkGaps:1'b0, expWrites:16'd0,   expOverrun:1'b0, expXfers:4'd0};
        vecs[5] = '{numPix:16'd8,   streamLen:4'd2, stream:64'h0000_0000_0000_2208, toggleValid:1'b0,
                    glitchAt:8'd3, chkGaps:1'b0, expWrites:16'd8,   expOverrun:1'b0, expXfers:4'd2};
        vecs[6] = '{numPix:16'd4,   streamLen:4'd2, stream:64'h0000_0000_0000_1104, toggleValid:1'b0,
                    glitchAt:8'd0, chkGaps:1'b0, expWrites:16'd4,   expOverrun:1'b0, expXfers:4'd2};

        rst           = 1'b1;
        bus.Start     = 1'b0;
        bus.NumPixels = '0;
        bus.InData    = '0;
        bus.InValid   = 1'b0;
        #12;
        checkResetValues("reset");
        #10;
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            $display("[TB] vector %0d: NumPixels=%0d", i, vecs[i].numPix);
            applyStimulus(vecs[i], 0);
        end

        // Abort a 200-byte run at its 50th write with an asynchronous reset.
        $display("[TB] reset during EMIT");
        applyStimulus('{numPix:16'd250, streamLen:4'd2, stream:64'h0000_0000_0000_5AC8, toggleValid:1'b0,
                        glitchAt:8'd0, chkGaps:1'b0, expWrites:16'd200, expOverrun:1'b0, expXfers:4'd2}, 50);
        checkOutput("emitBeforeReset", 32'(bus.WriteEnable), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkResetValues("midReset");
        bus.InValid = 1'b0;
        begin
            int doneBefore;
            doneBefore = doneCount;
            tick();
            tick();
            checkOutput("noDoneOnReset", 32'(doneCount - doneBefore), 32'd0);
        end
        rst = 1'b0;
        tick();
        applyStimulus(vecs[6], 0);

        $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
